vend_controller: RTL and testbench

Transaction sequencer for the vending machine. It accumulates credit from single-cycle coin codes and checks the selected product's price. On a successful purchase it issues one dispense pulse, then pays out change one coin per cycle (greedy quarters/dimes/nickels). It sits between the coin/product input decode and the dispense and coin-return actuators, all in the `clk50` domain.

---
 rtl/vend_controller.sv | 156 +++++++++++++++
 tb/tb_vend_controller.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : vend_controller
// Description : Vending transaction sequencer. It accumulates coin credit,
//               checks the price, issues a vend pulse and pays out change
//               one coin per cycle. Optional macro VEND_TIMEOUT_EN adds an
//               idle auto-refund.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_controller #(
    parameter int MAX_CREDIT     = 200,
    parameter int PRICE_BASE     = 25,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic [2:0] coin,
    input  logic [3:0] product,
    input  logic       cancel,
    output logic       dispense,
    output logic [3:0] item,
    output logic [2:0] change_coin,
    output logic       coin_reject,
    output logic [7:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    state_t     r_state;

    logic [7:0] w_coin_val;
    logic       w_coin_valid;
    logic [8:0] w_coin_sum;
    logic       w_coin_ok;
    logic [7:0] w_price;
    logic [2:0] w_chg_code;
    logic [7:0] w_chg_val;
    logic       w_timeout;

    always_comb begin
        w_coin_val   = 8'd0;
        w_coin_valid = 1'b1;
        case (coin)
            3'd1:    w_coin_val = 8'd5;
            3'd2:    w_coin_val = 8'd10;
            3'd3:    w_coin_val = 8'd25;
            3'd4:    w_coin_val = 8'd100;
            default: w_coin_valid = 1'b0;
        endcase
    end

    // Nine-bit sum so a dollar on top of a large credit cannot wrap past the ceiling check.
    assign w_coin_sum = {1'b0, credit} + {1'b0, w_coin_val};
    assign w_coin_ok  = w_coin_valid && (w_coin_sum <= 9'(MAX_CREDIT));

    assign w_price = 8'(PRICE_BASE) + {2'b00, product, 2'b00} + {4'b0000, product};

    always_comb begin
        w_chg_code = 3'd0;
        w_chg_val  = 8'd0;
        if (credit >= 8'd25) begin
            w_chg_code = 3'd3;
            w_chg_val  = 8'd25;
        end else if (credit >= 8'd10) begin
            w_chg_code = 3'd2;
            w_chg_val  = 8'd10;
        end else if (credit >= 8'd5) begin
            w_chg_code = 3'd1;
            w_chg_val  = 8'd5;
        end
    end

`ifdef VEND_TIMEOUT_EN
    logic [31:0] r_idle_cnt;

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_idle_cnt <= 32'd0;
        end else if ((r_state != IDLE) || (credit == 8'd0) || w_timeout ||
                     (product != 4'd0) || cancel || ((coin != 3'd0) && w_coin_ok)) begin
            r_idle_cnt <= 32'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 32'd1;
        end
    end

    assign w_timeout = (r_state == IDLE) && (credit != 8'd0) && (coin == 3'd0) &&
                       (product == 4'd0) && !cancel &&
                       (r_idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    // Without the counter the refund can never fire; the term is constant zero.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state     <= IDLE;
            dispense    <= 1'b0;
            item        <= 4'd0;
            change_coin <= 3'd0;
            coin_reject <= 1'b0;
            credit      <= 8'd0;
            busy        <= 1'b0;
        end else begin
            dispense    <= 1'b0;
            item        <= 4'd0;
            change_coin <= 3'd0;
            coin_reject <= (coin != 3'd0) && ((r_state != IDLE) || !w_coin_ok);
            case (r_state)
                IDLE: begin
                    if (coin != 3'd0) begin
                        if (w_coin_ok) begin
                            credit <= w_coin_sum[7:0];
                        end
                    end else if (product != 4'd0) begin
                        if (credit >= w_price) begin
                            credit   <= credit - w_price;
                            dispense <= 1'b1;
                            item     <= product;
                            r_state  <= VEND;
                            busy     <= 1'b1;
                        end
                    end else if ((cancel || w_timeout) && (credit != 8'd0)) begin
                        change_coin <= w_chg_code;
                        credit      <= credit - w_chg_val;
                        r_state     <= CHANGE;
                        busy        <= 1'b1;
                    end
                end
                VEND, CHANGE: begin
                    // The first refund coin leaves on the same edge that ends VEND.
                    if (credit != 8'd0) begin
                        change_coin <= w_chg_code;
                        credit      <= credit - w_chg_val;
                        r_state     <= CHANGE;
                        busy        <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_controller
// Description : Directed vector bench for vend_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_controller;

    logic       clk50 = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] coin = 3'd0;
    logic [3:0] product = 4'd0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic [3:0] item;
    logic [2:0] change_coin;
    logic       coin_reject;
    logic [7:0] credit;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    vend_controller #(
        .MAX_CREDIT    (200),
        .PRICE_BASE    (25),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .coin       (coin),
        .product    (product),
        .cancel     (cancel),
        .dispense   (dispense),
        .item       (item),
        .change_coin(change_coin),
        .coin_reject(coin_reject),
        .credit     (credit),
        .busy       (busy)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        logic        rst;
        logic [2:0]  coin;
        logic [3:0]  product;
        logic        cancel;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic string fmt(input logic [17:0] v);
        return $sformatf("disp=%0d item=%0d chg=%0d rej=%0d credit=%0d busy=%0d",
                         v[17], v[16:13], v[12:10], v[9], v[8:1], v[0]);
    endfunction

    function automatic logic [17:0] outs();
        return {dispense, item, change_coin, coin_reject, credit, busy};
    endfunction

    task automatic add(input logic r, input logic [2:0] c, input logic [3:0] p, input logic x,
                       input logic d, input logic [3:0] it, input logic [2:0] ch,
                       input logic rj, input logic [7:0] cr, input logic b);
        vec_t v;
        v.rst = r; v.coin = c; v.product = p; v.cancel = x;
        v.exp = {d, it, ch, rj, cr, b};
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [2:0] c, input logic [3:0] p, input logic x);
        @(negedge clk50);
        reset = r; coin = c; product = p; cancel = x;
        @(posedge clk50);
        #1;
    endtask

    task automatic check(input string name, input logic [17:0] exp);
        logic [17:0] act;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
        end
    endtask

    initial begin
        int cyc;
        // rst coin prod cancel | disp item chg rej credit busy
        add(1, 0, 0, 0,  0, 0, 0, 0,   0, 0);  // reset state
        // quarter, quarter, product 4 (price 45)
        add(0, 3, 0, 0,  0, 0, 0, 0,  25, 0);
        add(0, 3, 0, 0,  0, 0, 0, 0,  50, 0);
        add(0, 0, 4, 0,  1, 4, 0, 0,   5, 1);
        add(0, 0, 0, 0,  0, 0, 1, 0,   0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        // dollar, product 1 (price 30): change 3,3,2,2
        add(0, 4, 0, 0,  0, 0, 0, 0, 100, 0);
        add(0, 0, 1, 0,  1, 1, 0, 0,  70, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,  45, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,  20, 1);
        add(0, 0, 0, 0,  0, 0, 2, 0,  10, 1);
        add(0, 0, 0, 0,  0, 0, 2, 0,   0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        // dime, insufficient product 3, then cancel
        add(0, 2, 0, 0,  0, 0, 0, 0,  10, 0);
        add(0, 0, 3, 0,  0, 0, 0, 0,  10, 0);
        add(0, 0, 0, 1,  0, 0, 2, 0,   0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        // build 190, overflow and invalid coin, exact ceiling
        add(0, 4, 0, 0,  0, 0, 0, 0, 100, 0);
        add(0, 3, 0, 0,  0, 0, 0, 0, 125, 0);
        add(0, 3, 0, 0,  0, 0, 0, 0, 150, 0);
        add(0, 3, 0, 0,  0, 0, 0, 0, 175, 0);
        add(0, 2, 0, 0,  0, 0, 0, 0, 185, 0);
        add(0, 1, 0, 0,  0, 0, 0, 0, 190, 0);
        add(0, 3, 0, 0,  0, 0, 0, 1, 190, 0);
        add(0, 6, 0, 0,  0, 0, 0, 1, 190, 0);
        add(0, 2, 0, 0,  0, 0, 0, 0, 200, 0);
        add(0, 1, 0, 0,  0, 0, 0, 1, 200, 0);
        add(0, 2, 1, 1,  0, 0, 0, 1, 200, 0);  // coin wins, product/cancel ignored
        // product beats cancel; product 15 costs 100 -> four quarters back
        add(0, 0, 15, 1, 1, 15, 0, 0, 100, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,  75, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,  50, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,  25, 1);
        add(0, 0, 0, 0,  0, 0, 3, 0,   0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        // coins while busy are rejected; reset mid-CHANGE
        add(0, 4, 0, 0,  0, 0, 0, 0, 100, 0);
        add(0, 0, 1, 0,  1, 1, 0, 0,  70, 1);
        add(0, 1, 0, 0,  0, 0, 3, 1,  45, 1);
        add(0, 3, 0, 0,  0, 0, 3, 1,  20, 1);
        add(0, 0, 2, 1,  0, 0, 2, 0,  10, 1);
        add(1, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);
        // zero-credit corners
        add(0, 7, 0, 0,  0, 0, 0, 1,   0, 0);
        add(0, 0, 0, 1,  0, 0, 0, 0,   0, 0);
        add(0, 5, 0, 0,  0, 0, 0, 1,   0, 0);
        add(0, 1, 0, 0,  0, 0, 0, 0,   5, 0);
        add(0, 0, 1, 0,  0, 0, 0, 0,   5, 0);
        add(0, 0, 0, 1,  0, 0, 1, 0,   0, 1);
        add(0, 0, 0, 0,  0, 0, 0, 0,   0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].coin, vecs[i].product, vecs[i].cancel);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Idle hold / auto-refund after a dime
        step(0, 2, 0, 0);
        check("timeout_dime", {1'b0, 4'd0, 3'd0, 1'b0, 8'd10, 1'b0});
`ifdef VEND_TIMEOUT_EN
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0);
            if (change_coin != 3'd0) begin
                cyc = i;
                break;
            end
        end
        n_checks++;
        if (cyc != 20) begin
            n_fail++;
            $display("FAIL timeout_latency: refund after %0d idle cycles, expected 20", cyc);
        end
        check("timeout_refund", {1'b0, 4'd0, 3'd2, 1'b0, 8'd0, 1'b1});
        step(0, 0, 0, 0);
        check("timeout_idle", 18'd0);
`else
        cyc = 0;
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 0, 0);
            if (credit != 8'd10 || change_coin != 3'd0) cyc++;
        end
        n_checks++;
        if (cyc != 0) begin
            n_fail++;
            $display("FAIL hold_credit: %0d cycles deviated, expected 0 (credit now %0d)", cyc, credit);
        end
        step(0, 0, 0, 1);
        check("hold_cancel", {1'b0, 4'd0, 3'd2, 1'b0, 8'd0, 1'b1});
        step(0, 0, 0, 0);
        check("hold_idle", 18'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
